spi_frame_sequencer: RTL
========================

SPI_FRAME_SEQUENCER -- requirements
Module: spi_frame_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: i_Clk and i_Rst.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of queued 40-bit frames (power of 2, at least 2).
REQ-003 SHALL have parameter GAP_CLKS, default 4, meaning the idle i_Clk cycles between frames (0 is legal).
REQ-004 SHALL have parameter BUSY_TIMEOUT, default 16, meaning the maximum cycles to wait for the SPI master to drop ready.
REQ-005 SHALL have these ports (name, direction, width, meaning):
- i_Clk, in, 1: clock.
- i_Rst, in, 1: synchronous active-high reset.
- i_Enable, in, 1: permits new launches.
- i_Frame, in, 40: frame from the host.
- i_Frame_Valid, in, 1: host push request.
- o_Frame_Ready, out, 1: FIFO not full.
- o_TX_Byte, out, 40: frame to the SPI master.
- o_TX_DV, out, 1: one-cycle launch pulse.
- i_TX_Ready, in, 1: SPI master idle.
- o_Busy, out, 1: FSM not in IDLE.
- o_Fifo_Count, out, $clog2(FIFO_DEPTH)+1: occupancy.
- o_Frame_Count, out, 16: frames completed.
- o_Error, out, 1: sticky timeout flag.

Function
REQ-006 SHALL push i_Frame on a cycle where i_Frame_Valid and o_Frame_Ready are both 1; o_Frame_Ready SHALL equal (occupancy != FIFO_DEPTH), combinationally from registered pointers.
REQ-007 SHALL pop only on a launch; push and pop in the same cycle SHALL leave occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-008 SHALL implement the FSM states IDLE, WAIT_BUSY, WAIT_DONE and GAP.
REQ-009 In IDLE, when i_Enable, FIFO not empty and i_TX_Ready are all 1, it SHALL, at that edge, register o_TX_Byte to the FIFO head, set o_TX_DV to 1, pop, and move to WAIT_BUSY.
REQ-010 o_TX_DV SHALL be high for exactly one cycle per launch; o_TX_Byte SHALL hold its value until the next launch.
REQ-011 WAIT_BUSY SHALL move to WAIT_DONE on the first cycle with i_TX_Ready==0.
REQ-012 WAIT_DONE SHALL, on i_TX_Ready==1, increment o_Frame_Count (wrap 16'hFFFF to 0) and move to GAP, or to IDLE if GAP_CLKS==0.
REQ-013 GAP SHALL last exactly GAP_CLKS cycles and then return to IDLE.
REQ-014 Deasserting i_Enable mid-frame SHALL NOT abort the frame; it only blocks the next launch in IDLE.
REQ-015 o_Busy SHALL be 1 in every state except IDLE.
REQ-016 Back-to-back throughput: the first cycle from GAP exit to IDLE SHALL be able to launch the next frame.

Reset
REQ-017 i_Rst SHALL clear the FIFO pointers and FSM to IDLE, with o_TX_DV=0, o_TX_Byte=0, o_Frame_Count=0, o_Error=0, o_Fifo_Count=0, o_Busy=0 and o_Frame_Ready=1.
REQ-018 Reset mid-frame SHALL discard the queued frames and the in-flight tracking; no DV pulse SHALL occur in the reset cycle or the cycle after it.

Configuration
REQ-019 With macro SPI_FRAME_SEQ_TIMEOUT_EN defined, WAIT_BUSY SHALL count cycles; if i_TX_Ready is still 1 after BUSY_TIMEOUT cycles, it SHALL set o_Error (sticky until reset) and return to IDLE without incrementing o_Frame_Count.
REQ-020 Without SPI_FRAME_SEQ_TIMEOUT_EN, WAIT_BUSY SHALL wait indefinitely, o_Error SHALL be tied to 0, and no timeout counter SHALL be synthesized.

Structure
REQ-021 Package spi_pkg SHALL hold FRAME_W=40, FRAME_CNT_W=16 and the FSM state enum type.
REQ-022 Sub-module spi_frame_fifo (synchronous FIFO: push, pop, head, count, full, empty) SHALL be instantiated once.

Verification
REQ-023 Push 40'h12_3456_789A with i_TX_Ready=1 and i_Enable=1 -> o_TX_DV pulses for 1 cycle 2 cycles after the push, and o_TX_Byte=40'h12_3456_789A.
REQ-024 Push 4 frames with a model master (16 edges, CLKS_PER_HALF_BIT=2) -> 4 DV pulses in order, at least GAP_CLKS=4 idle cycles between ready-rise and the next DV, and o_Frame_Count=4.
REQ-025 Fill the FIFO (4 frames) with i_Enable=0 -> o_Frame_Ready=0 and o_Fifo_Count=4; a 5th push is ignored; setting i_Enable=1 drains exactly 4 frames.
REQ-026 With the macro defined, hold i_TX_Ready=1 after DV -> o_Error=1 after 16 cycles, FSM in IDLE, o_Frame_Count unchanged.
REQ-027 Assert i_Rst during WAIT_DONE with 2 frames queued -> all outputs at reset values next cycle, o_Fifo_Count=0, and no further DV.
REQ-028 Push and launch on the same cycle at occupancy 1 -> o_Fifo_Count stays 1.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared widths and FSM state type for the SPI frame sequencer.
package spi_pkg;

  localparam int unsigned FRAME_W     = 40;
  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StWaitBusy,
    StWaitDone,
    StGap
  } seq_state_e;

endpackage

// File: rtl/spi_frame_fifo.sv
// Synchronous frame FIFO; DEPTH must be a power of two so the extra pointer bit
// distinguishes full from empty and the pointers wrap naturally.
module spi_frame_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = FRAME_W
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == (AW + 1)'(DEPTH));
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define validity.
  always_ff @(posedge i_Clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/spi_frame_sequencer.sv
// Queues 40-bit frames and launches them one at a time into an SPI master.
// Define SPI_FRAME_SEQ_TIMEOUT_EN to enable the WAIT_BUSY timeout and sticky o_Error.
module spi_frame_sequencer
  import spi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned GAP_CLKS     = 4,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                        i_Clk,
  input  logic                        i_Rst,
  input  logic                        i_Enable,
  input  logic [FRAME_W-1:0]          i_Frame,
  input  logic                        i_Frame_Valid,
  output logic                        o_Frame_Ready,
  output logic [FRAME_W-1:0]          o_TX_Byte,
  output logic                        o_TX_DV,
  input  logic                        i_TX_Ready,
  output logic                        o_Busy,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
  output logic [FRAME_CNT_W-1:0]      o_Frame_Count,
  output logic                        o_Error
);

  localparam int unsigned GapW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  seq_state_e             state_q, state_d;
  logic                   launch, frame_done, gap_last, tmo_hit;
  logic                   fifo_full, fifo_empty;
  logic [FRAME_W-1:0]     fifo_head, tx_byte_q;
  logic                   tx_dv_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [GapW-1:0]        gap_cnt_q;

  spi_frame_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FRAME_W)
  ) u_fifo (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .push_i  (i_Frame_Valid),
    .data_i  (i_Frame),
    .pop_i   (launch),
    .head_o  (fifo_head),
    .count_o (o_Fifo_Count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign frame_done = (state_q == StWaitDone) && i_TX_Ready;
  // Unreachable compare value when GAP_CLKS is 0, since GAP is then skipped.
  assign gap_last   = (gap_cnt_q == GapW'(GAP_CLKS - 1));

`ifdef SPI_FRAME_SEQ_TIMEOUT_EN
  localparam int unsigned TmoW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  logic [TmoW-1:0] tmo_cnt_q;
  logic            error_q;

  assign tmo_hit = (state_q == StWaitBusy) && i_TX_Ready &&
                   (tmo_cnt_q == TmoW'(BUSY_TIMEOUT - 1));
  assign o_Error = error_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      tmo_cnt_q <= '0;
      error_q   <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == StWaitBusy) ? tmo_cnt_q + 1'b1 : '0;
      if (tmo_hit) error_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign o_Error = 1'b0;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (launch) state_d = StWaitBusy;
      StWaitBusy: begin
        if (!i_TX_Ready)  state_d = StWaitDone;
        else if (tmo_hit) state_d = StIdle;
      end
      StWaitDone: if (i_TX_Ready) state_d = (GAP_CLKS == 0) ? StIdle : StGap;
      StGap:      if (gap_last) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    launch = (state_q == StIdle) && i_Enable && !fifo_empty && i_TX_Ready;
    o_Busy = (state_q != StIdle);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= '0;
      frame_cnt_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      tx_dv_q <= launch;
      if (launch)     tx_byte_q   <= fifo_head;
      if (frame_done) frame_cnt_q <= frame_cnt_q + 1'b1;
      gap_cnt_q <= (state_q == StGap) ? gap_cnt_q + 1'b1 : '0;
    end
  end

  assign o_TX_DV       = tx_dv_q;
  assign o_TX_Byte     = tx_byte_q;
  assign o_Frame_Count = frame_cnt_q;
  assign o_Frame_Ready = !fifo_full;

endmodule
